i2c_target: RTL

I2C target (slave) endpoint: the responder for the team's I2C master, sharing its open-drain pin model (`*_oe` high pulls the line low). Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs writes and streams bytes to a local byte interface, and serves reads from that same interface. Sits between the pad logic and a register file or FIFO in SoC glue.

---
 rtl/i2c_target.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: filters SCL/SDA, detects START/STOP, matches a fixed
// 7-bit address, ACKs and streams written bytes out, serves read bytes in.
// Optional feature macro: I2C_TARGET_STRETCH_EN (clock stretching on reads).
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   scl_i, sda_i        raw bus levels (asynchronous)
//   scl_oe, sda_oe      1 = pull line low (open drain)
//   rx_data/rx_stb/rx_first  received byte, valid pulse, first-after-address
//   tx_data/tx_valid/tx_req  read byte, its valid flag, one-cycle request
//   evt_start, evt_stop pulses on filtered START/STOP; busy while addressed
module i2c_target #(
    parameter logic [6:0]  ADDR = 7'h42,
    parameter int unsigned FILT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_stb,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       evt_start,
    output logic       evt_stop,
    output logic       busy
);
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX_LOAD, S_TX, S_TX_ACK
    } state_t;

    // Line index 0 = SCL, 1 = SDA; idle bus level is high.
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] fcnt [2];

    // Synchronizer plus hold-time filter per line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            fcnt   <= '{default: '0};
        end else begin
            sync1  <= {sda_i, scl_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, sda_f, start_det, stop_det;
    assign sda_f     = filt[1];
    assign scl_rise  = filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] & filt_d[0];
    assign start_det = ~filt[1] & filt_d[1] & filt[0] & filt_d[0];
    assign stop_det  = filt[1] & ~filt_d[1] & filt[0] & filt_d[0];

    state_t     state, state_d;
    logic [7:0] shift, shift_d, rx_data_d;
    logic [2:0] bit_cnt, cnt_d;
    logic       first_pend, first_d;
    logic       sda_oe_d, scl_oe_d, rx_stb_d, rx_first_d, tx_req_d;
    logic       evt_start_d, evt_stop_d, busy_d;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            first_pend <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_stb     <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            evt_start  <= 1'b0;
            evt_stop   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            bit_cnt    <= cnt_d;
            first_pend <= first_d;
            scl_oe     <= scl_oe_d;
            sda_oe     <= sda_oe_d;
            rx_data    <= rx_data_d;
            rx_stb     <= rx_stb_d;
            rx_first   <= rx_first_d;
            tx_req     <= tx_req_d;
            evt_start  <= evt_start_d;
            evt_stop   <= evt_stop_d;
            busy       <= busy_d;
        end
    end

`ifndef I2C_TARGET_STRETCH_EN
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
`endif

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d     = state;
        shift_d     = shift;
        cnt_d       = bit_cnt;
        first_d     = first_pend;
        scl_oe_d    = scl_oe;
        sda_oe_d    = sda_oe;
        rx_data_d   = rx_data;
        rx_stb_d    = 1'b0;
        rx_first_d  = rx_first;
        tx_req_d    = 1'b0;
        evt_start_d = 1'b0;
        evt_stop_d  = 1'b0;
        busy_d      = busy;
        if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            scl_oe_d    = 1'b0;
            evt_start_d = 1'b1;
        end else if (stop_det) begin
            state_d    = S_IDLE;
            sda_oe_d   = 1'b0;
            scl_oe_d   = 1'b0;
            evt_stop_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    shift_d = {shift[6:0], sda_f};
                    cnt_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shift[6:0] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            first_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // sda_oe doubles as the ACK phase: set on first fall, cleared on second.
                S_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        if (shift[0]) begin
                            state_d  = S_TX_LOAD;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = S_RX;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d = {shift[6:0], sda_f};
                    cnt_d   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_d  = {shift[6:0], sda_f};
                        rx_stb_d   = 1'b1;
                        rx_first_d = first_pend;
                        first_d    = 1'b0;
                        state_d    = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    sda_oe_d = ~sda_oe;
                    if (sda_oe) state_d = S_RX;
                end
                S_TX_LOAD: begin
`ifdef I2C_TARGET_STRETCH_EN
                    if (tx_valid) begin
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        scl_oe_d = 1'b0;
                        state_d  = S_TX;
                    end else begin
                        scl_oe_d = 1'b1;
                    end
`else
                    shift_d  = tx_data;
                    sda_oe_d = ~tx_data[7];
                    state_d  = S_TX;
`endif
                end
                // Counter wraps to 0 on the 8th rise; the following fall ends the byte.
                S_TX: if (scl_rise) begin
                    cnt_d = bit_cnt + 3'd1;
                end else if (scl_fall) begin
                    if (bit_cnt == 3'd0) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_TX_ACK;
                    end else begin
                        shift_d  = {shift[6:0], 1'b0};
                        sda_oe_d = ~shift[6];
                    end
                end
                S_TX_ACK: if (scl_rise) begin
                    if (sda_f) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (scl_fall) begin
                    state_d  = S_TX_LOAD;
                    tx_req_d = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
